// File: rtl/axi_wr_burst_master.sv
// AXI4 write-burst master: takes one burst command at a time, issues AW, streams W beats from
// a simple valid/ready source, and tracks outstanding B responses up to MAX_OUTSTANDING.
module axi_wr_burst_master #(
    parameter int unsigned DATA_LEN        = 32,
    parameter int unsigned NUM_ID          = 4,
    parameter int unsigned NUM_USER        = 1,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [31:0]             cmd_addr,
    input  logic [7:0]              cmd_len,
    input  logic [2:0]              cmd_size,
    input  logic [1:0]              cmd_burst,
    input  logic [NUM_ID-1:0]       cmd_id,

    input  logic                    wd_valid,
    output logic                    wd_ready,
    input  logic [DATA_LEN-1:0]     wd_data,
    input  logic [DATA_LEN/8-1:0]   wd_strb,

    output logic                    AWVALID,
    input  logic                    AWREADY,
    output logic [31:0]             AWADDR,
    output logic [2:0]              AWSIZE,
    output logic [1:0]              AWBURST,
    output logic [NUM_ID-1:0]       AWID,
    output logic [7:0]              AWLEN,
    output logic [3:0]              AWCACHE,
    output logic [2:0]              AWPROT,
    output logic                    AWLOCK,
    output logic [3:0]              AWQOS,
    output logic [3:0]              AWREGION,
    output logic [NUM_USER-1:0]     AWUSER,

    output logic                    WVALID,
    input  logic                    WREADY,
    output logic                    WLAST,
    output logic [DATA_LEN-1:0]     WDATA,
    output logic [DATA_LEN/8-1:0]   WSTRB,
    output logic [NUM_USER-1:0]     WUSER,

    input  logic                    BVALID,
    output logic                    BREADY,
    input  logic [1:0]              BRESP,
    input  logic [NUM_ID-1:0]       BID,

    output logic                    rsp_valid,
    output logic [NUM_ID-1:0]       rsp_id,
    output logic [1:0]              rsp_resp,
    output logic                    cmd_err,
    output logic [3:0]              outstanding
);

    localparam logic [2:0] MaxSize = 3'($clog2(DATA_LEN / 8));
    localparam logic [3:0] MaxOut  = 4'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

    state_e              state_q;
    logic                awvalid_q;
    logic [31:0]         awaddr_q;
    logic [7:0]          awlen_q;
    logic [2:0]          awsize_q;
    logic [1:0]          awburst_q;
    logic [NUM_ID-1:0]   awid_q;
    logic [7:0]          beat_q;
    logic [3:0]          outstanding_q;
    logic                rsp_valid_q;
    logic [NUM_ID-1:0]   rsp_id_q;
    logic [1:0]          rsp_resp_q;
    logic                cmd_err_q;

    logic cmd_hs;
    logic cmd_illegal;
    logic wrap_len_ok;
    logic aw_hs;
    logic w_hs;
    logic b_hs;

    // Gated by ARESETn so cmd_ready is low during reset yet high on the first edge after it.
    assign cmd_ready   = ARESETn && (state_q == StIdle) && (outstanding_q < MaxOut);
    assign cmd_hs      = cmd_valid && cmd_ready;
    assign wrap_len_ok = (cmd_len == 8'd1) || (cmd_len == 8'd3) ||
                         (cmd_len == 8'd7) || (cmd_len == 8'd15);
    assign cmd_illegal = (cmd_size > MaxSize) || (cmd_burst == 2'd3) ||
                         ((cmd_burst == 2'd2) && !wrap_len_ok);

    assign WVALID   = (state_q == StData) && wd_valid;
    assign wd_ready = (state_q == StData) && WREADY;
    assign WLAST    = (state_q == StData) && (beat_q == awlen_q);
    assign WDATA    = wd_data;
    assign WSTRB    = wd_strb;
    assign WUSER    = '0;

    assign AWVALID  = awvalid_q;
    assign AWADDR   = awaddr_q;
    assign AWLEN    = awlen_q;
    assign AWSIZE   = awsize_q;
    assign AWBURST  = awburst_q;
    assign AWID     = awid_q;
    assign AWCACHE  = 4'b0011;
    assign AWPROT   = 3'b000;
    assign AWLOCK   = 1'b0;
    assign AWQOS    = 4'b0000;
    assign AWREGION = 4'b0000;
    assign AWUSER   = '0;

    assign BREADY      = (outstanding_q != 4'd0);
    assign aw_hs       = awvalid_q && AWREADY;
    assign w_hs        = WVALID && WREADY;
    assign b_hs        = BVALID && BREADY;

    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_resp    = rsp_resp_q;
    assign cmd_err     = cmd_err_q;
    assign outstanding = outstanding_q;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q       <= StIdle;
            awvalid_q     <= 1'b0;
            awaddr_q      <= '0;
            awlen_q       <= '0;
            awsize_q      <= '0;
            awburst_q     <= '0;
            awid_q        <= '0;
            beat_q        <= '0;
            outstanding_q <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= '0;
            rsp_resp_q    <= '0;
            cmd_err_q     <= 1'b0;
        end else begin
            cmd_err_q   <= 1'b0;
            rsp_valid_q <= b_hs;
            if (b_hs) begin
                rsp_id_q   <= BID;
                rsp_resp_q <= BRESP;
            end

            if (aw_hs && !b_hs) begin
                outstanding_q <= outstanding_q + 4'd1;
            end else if (b_hs && !aw_hs) begin
                outstanding_q <= outstanding_q - 4'd1;
            end

            unique case (state_q)
                StIdle: begin
                    if (cmd_hs) begin
                        if (cmd_illegal) begin
                            cmd_err_q <= 1'b1;
                        end else begin
                            awaddr_q  <= cmd_addr;
                            awlen_q   <= cmd_len;
                            awsize_q  <= cmd_size;
                            awburst_q <= cmd_burst;
                            awid_q    <= cmd_id;
                            awvalid_q <= 1'b1;
                            state_q   <= StAddr;
                        end
                    end
                end
                StAddr: begin
                    if (AWREADY) begin
                        awvalid_q <= 1'b0;
                        beat_q    <= '0;
                        state_q   <= StData;
                    end
                end
                StData: begin
                    if (w_hs) begin
                        if (WLAST) begin
                            beat_q  <= '0;
                            state_q <= StIdle;
                        end else begin
                            beat_q <= beat_q + 8'd1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_wr_burst_master.sv
// Directed bench for axi_wr_burst_master (DATA_LEN=32, MAX_OUTSTANDING=2).
module tb_axi_wr_burst_master;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic        cmd_valid, cmd_ready;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [2:0]  cmd_size;
    logic [1:0]  cmd_burst;
    logic [3:0]  cmd_id;
    logic        wd_valid, wd_ready;
    logic [31:0] wd_data;
    logic [3:0]  wd_strb;
    logic        AWVALID, AWREADY;
    logic [31:0] AWADDR;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic [3:0]  AWID;
    logic [7:0]  AWLEN;
    logic [3:0]  AWCACHE;
    logic [2:0]  AWPROT;
    logic        AWLOCK;
    logic [3:0]  AWQOS, AWREGION;
    logic [0:0]  AWUSER, WUSER;
    logic        WVALID, WREADY, WLAST;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        BVALID, BREADY;
    logic [1:0]  BRESP;
    logic [3:0]  BID;
    logic        rsp_valid, cmd_err;
    logic [3:0]  rsp_id;
    logic [1:0]  rsp_resp;
    logic [3:0]  outstanding;

    int total = 0;
    int bad   = 0;
    int nbeats;

    always #5 ACLK = ~ACLK;

    axi_wr_burst_master #(
        .DATA_LEN(32), .NUM_ID(4), .NUM_USER(1), .MAX_OUTSTANDING(2)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .cmd_size(cmd_size), .cmd_burst(cmd_burst), .cmd_id(cmd_id),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWSIZE(AWSIZE),
        .AWBURST(AWBURST), .AWID(AWID), .AWLEN(AWLEN), .AWCACHE(AWCACHE), .AWPROT(AWPROT),
        .AWLOCK(AWLOCK), .AWQOS(AWQOS), .AWREGION(AWREGION), .AWUSER(AWUSER),
        .WVALID(WVALID), .WREADY(WREADY), .WLAST(WLAST), .WDATA(WDATA), .WSTRB(WSTRB),
        .WUSER(WUSER),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP), .BID(BID),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_resp(rsp_resp), .cmd_err(cmd_err),
        .outstanding(outstanding)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic set_cmd(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                           input logic [1:0] b, input logic [3:0] id);
        cmd_addr  = a;
        cmd_len   = l;
        cmd_size  = s;
        cmd_burst = b;
        cmd_id    = id;
    endtask

    initial begin
        ARESETn = 1'b0;
        cmd_valid = 1'b0; set_cmd(32'h0, 8'd0, 3'd0, 2'd0, 4'd0);
        wd_valid = 1'b0; wd_data = '0; wd_strb = 4'hF;
        AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'd0; BID = 4'd0;

        // Reset state
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_awvalid", 32'(AWVALID), 32'd0);
        chk("rst_wvalid", 32'(WVALID), 32'd0);
        chk("rst_bready", 32'(BREADY), 32'd0);
        chk("rst_outstanding", 32'(outstanding), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_cmd_err", 32'(cmd_err), 32'd0);
        chk("awcache_const", 32'(AWCACHE), 32'h3);
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        ARESETn = 1'b1;
        #1;
        chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);

        // Single INCR burst, no backpressure
        AWREADY = 1'b1; WREADY = 1'b1;
        set_cmd(32'h1000, 8'd3, 3'd2, 2'd1, 4'd5);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("t1_awvalid", 32'(AWVALID), 32'd1);
        chk("t1_awaddr", AWADDR, 32'h1000);
        chk("t1_awlen", 32'(AWLEN), 32'd3);
        chk("t1_awid", 32'(AWID), 32'd5);
        chk("t1_awsize", 32'(AWSIZE), 32'd2);
        chk("t1_cmd_ready_busy", 32'(cmd_ready), 32'd0);
        tick();
        chk("t1_aw_done", 32'(AWVALID), 32'd0);
        chk("t1_outstanding", 32'(outstanding), 32'd1);
        wd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wd_data = 32'hA0 + 32'(i);
            #1;
            chk("t1_wvalid", 32'(WVALID), 32'd1);
            chk("t1_wdata", WDATA, 32'hA0 + 32'(i));
            chk("t1_wlast", 32'(WLAST), (i == 3) ? 32'd1 : 32'd0);
            tick();
        end
        wd_valid = 1'b0;
        #1;
        chk("t1_idle_wd_ready", 32'(wd_ready), 32'd0);
        chk("t1_bready", 32'(BREADY), 32'd1);
        BVALID = 1'b1; BID = 4'd5; BRESP = 2'd0;
        tick();
        BVALID = 1'b0;
        chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t1_rsp_id", 32'(rsp_id), 32'd5);
        chk("t1_rsp_resp", 32'(rsp_resp), 32'd0);
        chk("t1_out_zero", 32'(outstanding), 32'd0);
        tick();
        chk("t1_rsp_pulse_end", 32'(rsp_valid), 32'd0);
        chk("t1_bready_low", 32'(BREADY), 32'd0);

        // AW backpressure and gappy W stream
        AWREADY = 1'b0;
        set_cmd(32'h2000, 8'd2, 3'd2, 2'd1, 4'd3);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t2_awvalid_hold", 32'(AWVALID), 32'd1);
            chk("t2_awaddr_hold", AWADDR, 32'h2000);
            chk("t2_wvalid_addr", 32'(WVALID), 32'd0);
            tick();
        end
        AWREADY = 1'b1;
        tick();
        AWREADY = 1'b0;
        nbeats = 0;
        for (int c = 0; c < 6; c++) begin
            wd_valid = (c % 2 == 0) && (nbeats < 3);
            wd_data = 32'(c);
            #1;
            chk("t2_wvalid", 32'(WVALID), 32'(wd_valid));
            chk("t2_wlast", 32'(WLAST), (nbeats == 2) ? 32'd1 : 32'd0);
            if (wd_valid) nbeats++;
            tick();
        end
        wd_valid = 1'b0;
        BVALID = 1'b1; BID = 4'd3; BRESP = 2'd2;
        tick();
        BVALID = 1'b0;
        chk("t2_rsp_id", 32'(rsp_id), 32'd3);
        chk("t2_rsp_resp", 32'(rsp_resp), 32'd2);

        // Illegal commands
        set_cmd(32'h0, 8'd0, 3'd3, 2'd1, 4'd0);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("t3_size_err", 32'(cmd_err), 32'd1);
        chk("t3_size_noaw", 32'(AWVALID), 32'd0);
        chk("t3_size_idle", 32'(cmd_ready), 32'd1);
        tick();
        chk("t3_err_pulse_end", 32'(cmd_err), 32'd0);
        set_cmd(32'h0, 8'd2, 3'd2, 2'd2, 4'd0);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("t3_wrap_err", 32'(cmd_err), 32'd1);
        chk("t3_wrap_noaw", 32'(AWVALID), 32'd0);
        set_cmd(32'h0, 8'd0, 3'd2, 2'd3, 4'd0);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("t3_burst3_err", 32'(cmd_err), 32'd1);
        chk("t3_burst3_noaw", 32'(AWVALID), 32'd0);
        tick();

        // Outstanding limit with len=0 bursts and B withheld
        AWREADY = 1'b1; WREADY = 1'b1; wd_valid = 1'b1;
        set_cmd(32'h3000, 8'd0, 3'd2, 2'd1, 4'd1);
        cmd_valid = 1'b1;
        repeat (6) tick();
        chk("t4_cmd_ready_full", 32'(cmd_ready), 32'd0);
        chk("t4_outstanding_2", 32'(outstanding), 32'd2);
        tick();
        chk("t4_still_full", 32'(cmd_ready), 32'd0);
        chk("t4_no_aw", 32'(AWVALID), 32'd0);
        BVALID = 1'b1; BID = 4'd1; BRESP = 2'd0;
        #1;
        chk("t4_ready_before_b", 32'(cmd_ready), 32'd0);
        tick();
        BVALID = 1'b0;
        chk("t4_ready_after_b", 32'(cmd_ready), 32'd1);
        chk("t4_rsp_valid", 32'(rsp_valid), 32'd1);
        set_cmd(32'h3040, 8'd0, 3'd2, 2'd1, 4'd2);
        tick();
        cmd_valid = 1'b0;
        chk("t4_third_aw", 32'(AWVALID), 32'd1);
        chk("t4_third_addr", AWADDR, 32'h3040);
        chk("t4_out_1", 32'(outstanding), 32'd1);

        // AW and B handshakes in the same cycle
        BVALID = 1'b1; BID = 4'd2; BRESP = 2'd0;
        tick();
        BVALID = 1'b0;
        chk("t5_out_same", 32'(outstanding), 32'd1);
        chk("t5_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t5_rsp_id", 32'(rsp_id), 32'd2);
        chk("t5_data_wvalid", 32'(WVALID), 32'd1);
        chk("t5_data_wlast", 32'(WLAST), 32'd1);
        tick();
        wd_valid = 1'b0;
        #1;
        chk("t5_idle_wvalid", 32'(WVALID), 32'd0);

        // Stray BVALID with nothing outstanding
        BVALID = 1'b1; BID = 4'd2;
        tick();
        chk("t6_out_0", 32'(outstanding), 32'd0);
        tick();
        BVALID = 1'b0;
        chk("t6_no_underflow", 32'(outstanding), 32'd0);
        chk("t6_no_rsp", 32'(rsp_valid), 32'd0);
        chk("t6_bready_low", 32'(BREADY), 32'd0);

        // Reset at beat 2 of 4
        set_cmd(32'h4000, 8'd3, 3'd2, 2'd1, 4'd7);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        wd_valid = 1'b1;
        tick();
        chk("t7_mid_wvalid", 32'(WVALID), 32'd1);
        chk("t7_mid_bready", 32'(BREADY), 32'd1);
        ARESETn = 1'b0;
        #1;
        chk("t7_rst_awvalid", 32'(AWVALID), 32'd0);
        chk("t7_rst_wvalid", 32'(WVALID), 32'd0);
        chk("t7_rst_bready", 32'(BREADY), 32'd0);
        chk("t7_rst_out", 32'(outstanding), 32'd0);
        chk("t7_rst_wlast", 32'(WLAST), 32'd0);
        set_cmd(32'h5000, 8'd1, 3'd2, 2'd1, 4'd4);
        cmd_valid = 1'b1;
        @(negedge ACLK);
        ARESETn = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("t7_post_awvalid", 32'(AWVALID), 32'd1);
        chk("t7_post_awaddr", AWADDR, 32'h5000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_wr_burst_master.md
AXI_WR_BURST_MASTER -- requirements
Module: axi_wr_burst_master

Interface
REQ-001 SHALL have parameter DATA_LEN, default 32: WDATA width in bits; legal values 32, 64, 128.
REQ-002 SHALL have parameter NUM_ID, default 4: AWID/BID width.
REQ-003 SHALL have parameter NUM_USER, default 1: AWUSER/WUSER width.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 4: maximum number of bursts whose address has been accepted but whose B response has not yet returned; range 1..15.
REQ-005 SHALL have one clock and an asynchronous active-low reset:
- ACLK  in  1  clock; all logic rises on posedge.
- ARESETn  in  1  asynchronous active-low reset.
REQ-006 SHALL have these ports:
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted this cycle.
- cmd_addr  in  32  burst start address.
- cmd_len  in  8  beats minus 1.
- cmd_size  in  3  log2 bytes per beat.
- cmd_burst  in  2  burst type: 0 FIXED, 1 INCR, 2 WRAP.
- cmd_id  in  NUM_ID  transaction ID.
- wd_valid  in  1  write-data beat offered.
- wd_ready  out  1  write-data beat accepted.
- wd_data  in  DATA_LEN  write data.
- wd_strb  in  DATA_LEN/8  write strobes.
- AWVALID, AWREADY, AWADDR[31:0], AWSIZE[2:0], AWBURST[1:0], AWID[NUM_ID], AWLEN[7:0]  out/in/out...  AXI4 write-address channel.
- AWCACHE[3:0], AWPROT[2:0], AWLOCK, AWQOS[3:0], AWREGION[3:0], AWUSER[NUM_USER]  out  constants 4'b0011, 0, 0, 0, 0, 0.
- WVALID, WREADY, WLAST, WDATA[DATA_LEN], WSTRB[DATA_LEN/8], WUSER[NUM_USER]  out/in/out  AXI4 write-data channel; WUSER is constant 0.
- BVALID, BREADY, BRESP[1:0], BID[NUM_ID]  in/out/in/in  AXI4 write-response channel.
- rsp_valid  out  1  one-cycle pulse per completed burst.
- rsp_id  out  NUM_ID  ID of the completed burst.
- rsp_resp  out  2  BRESP of the completed burst.
- cmd_err  out  1  one-cycle pulse when a command is rejected.
- outstanding  out  4  current outstanding-burst count.

Function
REQ-007 SHALL use a state machine with states IDLE, ADDR and DATA.
REQ-008 SHALL drive cmd_ready=1 only in IDLE, and only when outstanding < MAX_OUTSTANDING.
REQ-009 A command is accepted on cmd_valid&cmd_ready; an accepted command SHALL be latched into the AW fields.
REQ-010 On accepting an illegal command, the block SHALL pulse cmd_err for 1 cycle the next cycle, issue no AXI traffic, and stay in IDLE. A command is illegal if either:
- cmd_size > log2(DATA_LEN/8); or
- cmd_burst==3; or
- cmd_burst==WRAP and cmd_len is not in {1,3,7,15}.
REQ-011 On accepting a legal command, the block SHALL go IDLE->ADDR and assert AWVALID the following cycle.
REQ-012 Once asserted, AWVALID SHALL hold with all AW fields stable until AWREADY is sampled high; the block SHALL then go ADDR->DATA.
REQ-013 In DATA, WVALID SHALL equal wd_valid and wd_ready SHALL equal WREADY (combinational pass-through); WDATA and WSTRB SHALL be wd_data and wd_strb.
REQ-014 An internal 8-bit beat counter SHALL reset to 0 on entry to DATA and increment on each WVALID&WREADY.
- WLAST SHALL be 1 exactly when the beat counter == latched len.
- The handshake on the WLAST beat SHALL return the FSM to IDLE.
REQ-015 In IDLE and ADDR, wd_ready and WVALID SHALL be 0.
REQ-016 The outstanding counter SHALL increment on each AW handshake and decrement on each B handshake; when both occur in the same cycle it SHALL stay unchanged.
REQ-017 BREADY SHALL be 1 whenever outstanding > 0, and 0 otherwise.
REQ-018 On each B handshake, the block SHALL drive rsp_valid=1 for one cycle in the following cycle, with rsp_id=BID and rsp_resp=BRESP registered from the handshake.
REQ-019 A BVALID seen while outstanding==0 SHALL be ignored and SHALL NOT underflow the counter.
REQ-020 A B response arriving while the block is in ADDR or DATA SHALL be handled per REQ-016..018 without disturbing the state machine.
REQ-021 Latency from cmd handshake to AWVALID SHALL be 1 cycle; latency from B handshake to rsp_valid SHALL be 1 cycle.

Reset
REQ-022 While ARESETn=0, asynchronously and independent of ACLK:
- state SHALL be IDLE;
- AWVALID, WVALID, WLAST, BREADY, cmd_ready, wd_ready, rsp_valid and cmd_err SHALL be 0;
- outstanding, the beat counter and all latched fields SHALL be 0.
REQ-023 Reset asserted mid-burst SHALL abandon the burst; after release the block SHALL accept a new command on the first posedge with cmd_valid=1.

Verification
REQ-024 Single INCR: cmd addr=0x1000, len=3, size=2, id=5 with AWREADY=1 and WREADY=1 -> one AW with AWLEN=3, then 4 W beats with WLAST on beat 4; BVALID with BID=5 and BRESP=0 -> rsp_valid pulse with rsp_id=5 and rsp_resp=0.
REQ-025 Backpressure: AWREADY held low for 5 cycles -> AWVALID and AWADDR stay stable; wd_valid toggling every other cycle -> WLAST lands on exactly beat len+1.
REQ-026 Outstanding limit: MAX_OUTSTANDING=2, three len=0 commands, B withheld -> cmd_ready=0 after 2 AW handshakes, outstanding=2; one B -> third command accepted.
REQ-027 Illegal commands: DATA_LEN=32 with size=3, and WRAP with len=2 -> cmd_err pulses, AWVALID stays 0.
REQ-028 Simultaneous events: AW handshake and B handshake in the same cycle -> outstanding unchanged.
REQ-029 Reset mid-burst: ARESETn low at beat 2 of 4 -> AWVALID, WVALID and BREADY fall immediately and outstanding=0.
